// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr reads as 0).
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data_in,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     cand;
    logic [IW-1:0]     win;
    logic              found;
    logic              grant;
    logic [7:0]        win_byte;
    logic [N_REQ-1:0]  ack_d;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % 32'(N_REQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_byte = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(win) == i) begin
                win_byte = data_in[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        ack_d   = '0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant      = 1'b1;
                    ack_d[win] = 1'b1;
                    state_d    = FRAME;
                    cnt_d      = CW'(FRAME_CYCLES - 1);
                end
            end
            FRAME: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack      <= ack_d;
            tx_start <= grant;
            if (grant) begin
                tx_data  <= win_byte;
                grant_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences, random vs. reference model.
// Expectations follow UART_ARB_FIXED_PRIO_EN when it is defined.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int F = 10;
    localparam int G = 1;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic [1:0]  grant_id;

    logic        rst0;
    logic [3:0]  req0;
    logic [31:0] data0;
    logic [3:0]  ack0;
    logic [7:0]  tx_data0;
    logic        tx_start0;
    logic        busy0;
    logic [1:0]  grant_id0;

    uart_tx_arbiter #(.N_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data), .ack(ack),
        .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.N_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .data_in(data0), .ack(ack0),
        .tx_data(tx_data0), .tx_start(tx_start0), .busy(busy0), .grant_id(grant_id0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mcheck  = 1'b0;

    // Reference model: busy-cycles-remaining counter plus a rotating search base.
    int         m_left = 0;
    int         m_ptr  = 0;
    logic [3:0] e_ack  = '0;
    logic       e_start = 1'b0;
    logic [7:0] e_data = '0;
    int         e_gid  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  e_ack;
        logic        e_start;
        logic        e_busy;
        logic [7:0]  e_data;
        logic [1:0]  e_gid;
    } vec_t;
    vec_t vt[16];

    int order[8];
    int times[8];
    int n_got;
    int low_cnt;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic model_edge();
        int w;
        int base;
        w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        if (rst) begin
            m_left = 0; m_ptr = 0; e_ack = '0; e_start = 1'b0; e_data = '0; e_gid = 0;
        end else if (m_left == 0 && req != 4'b0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(base + k) % N]) w = (base + k) % N;
            end
            e_ack   = 4'(1 << w);
            e_start = 1'b1;
            e_data  = data[8*w +: 8];
            e_gid   = w;
            m_ptr   = (w + 1) % N;
            m_left  = F + G;
        end else begin
            e_ack   = '0;
            e_start = 1'b0;
            if (m_left > 0) m_left--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (mcheck) begin
            chk("rnd.ack",      32'(ack),      32'(e_ack));
            chk("rnd.tx_start", 32'(tx_start), 32'(e_start));
            chk("rnd.tx_data",  32'(tx_data),  32'(e_data));
            chk("rnd.grant_id", 32'(grant_id), 32'(e_gid));
            chk("rnd.busy",     32'(busy),     32'(m_left > 0));
        end
    endtask

    task automatic do_reset();
        req = '0; rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; data = '0;
        rst0 = 1'b1; req0 = '0; data0 = 32'h5A5A_5A5A;

        // Single request, request during busy, reset afterwards
        vt[0] = '{1'b1, 4'b0000, 32'h0,          4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
        vt[1] = '{1'b0, 4'b0100, 32'h0061_0000,  4'b0100, 1'b1, 1'b1, 8'h61, 2'd2};
        for (int i = 2; i <= 5; i++)
            vt[i] = '{1'b0, 4'b0000, 32'h007E_0000, 4'b0000, 1'b0, 1'b1, 8'h61, 2'd2};
        for (int i = 6; i <= 11; i++)
            vt[i] = '{1'b0, 4'b1000, 32'h337E_0000, 4'b0000, 1'b0, 1'b1, 8'h61, 2'd2};
        vt[12] = '{1'b0, 4'b1000, 32'h337E_0000, 4'b0000, 1'b0, 1'b0, 8'h61, 2'd2};
        vt[13] = '{1'b0, 4'b1000, 32'h337E_0000, 4'b1000, 1'b1, 1'b1, 8'h33, 2'd3};
        vt[14] = '{1'b0, 4'b0000, 32'h007E_0000, 4'b0000, 1'b0, 1'b1, 8'h33, 2'd3};
        vt[15] = '{1'b1, 4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};

        for (int i = 0; i < 16; i++) begin
            rst = vt[i].rst; req = vt[i].req; data = vt[i].data;
            step();
            chk($sformatf("vec%0d.ack", i),      32'(ack),      32'(vt[i].e_ack));
            chk($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(vt[i].e_start));
            chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(vt[i].e_busy));
            chk($sformatf("vec%0d.tx_data", i),  32'(tx_data),  32'(vt[i].e_data));
            chk($sformatf("vec%0d.grant_id", i), 32'(grant_id), 32'(vt[i].e_gid));
        end

        // Simultaneous requests, each dropped after its ack
        do_reset();
        req = 4'b1111; data = 32'h4443_4241; n_got = 0;
        for (int c = 0; c < 80 && n_got < 4; c++) begin
            step();
            if (tx_start) begin
                order[n_got] = int'(grant_id); times[n_got] = cyc; n_got++;
                chk("simul.tx_data", 32'(tx_data), 32'(8'h41 + grant_id));
                req[grant_id] = 1'b0;
            end
        end
        chk("simul.count", 32'(n_got), 32'd4);
        for (int i = 0; i < n_got; i++) begin
            chk($sformatf("simul.order%0d", i), 32'(order[i]), 32'(i));
            if (i > 0) chk($sformatf("simul.spacing%0d", i), 32'(times[i] - times[i-1]), 32'd12);
        end

        // Fairness under continuous request
        do_reset();
        req = 4'b0011; data = 32'h0000_B1B0; n_got = 0;
        for (int c = 0; c < 80 && n_got < 4; c++) begin
            step();
            if (tx_start) begin
                order[n_got] = int'(grant_id); times[n_got] = cyc; n_got++;
            end
        end
        chk("fair.count", 32'(n_got), 32'd4);
        for (int i = 0; i < n_got; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            chk($sformatf("fair.order%0d", i), 32'(order[i]), 32'd0);
`else
            chk($sformatf("fair.order%0d", i), 32'(order[i]), 32'(i % 2));
`endif
            if (i > 0) chk($sformatf("fair.spacing%0d", i), 32'(times[i] - times[i-1]), 32'd12);
        end

        // Reset at frame cycle 5 with the request still held
        do_reset();
        req = 4'b0100; data = 32'h0061_0000;
        step();
        chk("rstmid.start0", 32'(tx_start), 32'd1);
        for (int c = 0; c < 5; c++) step();
        chk("rstmid.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("rstmid.busy",     32'(busy),     32'd0);
        chk("rstmid.tx_data",  32'(tx_data),  32'd0);
        chk("rstmid.tx_start", 32'(tx_start), 32'd0);
        chk("rstmid.ack",      32'(ack),      32'd0);
        chk("rstmid.grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        step();
        chk("rstmid.regrant_start", 32'(tx_start), 32'd1);
        chk("rstmid.regrant_ack",   32'(ack),      32'b0100);
        chk("rstmid.regrant_id",    32'(grant_id), 32'd2);
        req = '0;

        // Zero-gap build, request held continuously
        step();
        rst0 = 1'b0; req0 = 4'b0001; n_got = 0; low_cnt = 0;
        for (int c = 0; c < 60 && n_got < 4; c++) begin
            step();
            if (n_got > 0 && !busy0) low_cnt++;
            if (tx_start0) begin
                times[n_got] = cyc; n_got++;
            end
        end
        chk("zgap.count", 32'(n_got), 32'd4);
        for (int i = 1; i < n_got; i++)
            chk($sformatf("zgap.spacing%0d", i), 32'(times[i] - times[i-1]), 32'd11);
        chk("zgap.idle_cycles", 32'(low_cnt), 32'(n_got - 1));
        rst0 = 1'b1; req0 = '0;

        // Randomized traffic against the reference model
        do_reset();
        mcheck = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
                else if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            end
            data = $urandom;
            step();
        end
        mcheck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
